controller: RTL and testbench

Instruction-sequencing controller for the simple RISC CPU. It drives the control side of the fetch/execute datapath: `inc_pc` and `ld_pc` into the program counter, plus the memory, instruction-register, accumulator and bus-enable strobes. It steps through a fixed 8-phase instruction cycle and decodes the 3-bit opcode to qualify each strobe.

---
 rtl/controller_if.sv | 43 ++++
 rtl/controller.sv | 119 +++++++++++
 tb/tb_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/controller_if.sv
// Control-side bundle between the instruction sequencer and the CPU datapath.
// The master side is the controller; the slave side is the datapath/IR that supplies opcode/zero.
interface controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       rd;
    logic       ld_ir;
    logic       inc_pc;
    logic       ld_pc;
    logic       halt;
    logic       data_e;
    logic       ld_ac;
    logic       wr;

    modport master (
        input  opcode,
        input  zero,
        output sel,
        output rd,
        output ld_ir,
        output inc_pc,
        output ld_pc,
        output halt,
        output data_e,
        output ld_ac,
        output wr
    );

    modport slave (
        output opcode,
        output zero,
        input  sel,
        input  rd,
        input  ld_ir,
        input  inc_pc,
        input  ld_pc,
        input  halt,
        input  data_e,
        input  ld_ac,
        input  wr
    );
endinterface

// File: rtl/controller.sv
// Instruction-sequencing controller: steps a fixed 8-phase instruction cycle and
// decodes the opcode into datapath strobes. Strobes are a combinational decode of phase state.
module controller (
    input logic          clk,
    input logic          rst,
    controller_if.master bus
);
    typedef enum logic [2:0] {
        StInstAddr  = 3'd0,
        StInstFetch = 3'd1,
        StInstLoad  = 3'd2,
        StIdle      = 3'd3,
        StOpAddr    = 3'd4,
        StOpFetch   = 3'd5,
        StAluOp     = 3'd6,
        StStore     = 3'd7
    } phase_e;

    localparam logic [2:0] OpHlt = 3'd0;
    localparam logic [2:0] OpSkz = 3'd1;
    localparam logic [2:0] OpAdd = 3'd2;
    localparam logic [2:0] OpAnd = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpLda = 3'd5;
    localparam logic [2:0] OpSto = 3'd6;
    localparam logic [2:0] OpJmp = 3'd7;

    phase_e phase_q, phase_d;
    logic   halted_q, halted_d;

    logic is_hlt;
    logic is_skz;
    logic is_sto;
    logic is_jmp;
    logic is_aluop;

    always_comb begin
        is_hlt   = (bus.opcode == OpHlt);
        is_skz   = (bus.opcode == OpSkz);
        is_sto   = (bus.opcode == OpSto);
        is_jmp   = (bus.opcode == OpJmp);
        is_aluop = (bus.opcode == OpAdd) || (bus.opcode == OpAnd) ||
                   (bus.opcode == OpXor) || (bus.opcode == OpLda);
    end

    // Once halted, the phase parks at OP_ADDR until reset.
    always_comb begin
        halted_d = halted_q;
        if (phase_q == StOpAddr && is_hlt) begin
            halted_d = 1'b1;
        end
        if (halted_d) begin
            phase_d = StOpAddr;
        end else begin
            phase_d = phase_e'(phase_q + 3'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= StInstAddr;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.halt   = halted_q;
        bus.data_e = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        unique case (phase_q)
            StInstAddr: begin
                bus.sel = 1'b1;
            end
            StInstFetch: begin
                bus.sel = 1'b1;
                bus.rd  = 1'b1;
            end
            StInstLoad, StIdle: begin
                bus.sel   = 1'b1;
                bus.rd    = 1'b1;
                bus.ld_ir = 1'b1;
            end
            StOpAddr: begin
                if (is_hlt) begin
                    bus.halt = 1'b1;
                end
                bus.inc_pc = !is_hlt && !halted_q;
            end
            StOpFetch: begin
                bus.rd = is_aluop;
            end
            StAluOp: begin
                bus.rd     = is_aluop;
                bus.inc_pc = is_skz && bus.zero;
                bus.ld_pc  = is_jmp;
                bus.data_e = is_sto;
            end
            StStore: begin
                bus.rd     = is_aluop;
                bus.ld_pc  = is_jmp;
                bus.data_e = is_sto;
                bus.ld_ac  = is_aluop;
                bus.wr     = is_sto;
            end
            default: begin
                bus.sel = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the controller: stimulus pushes per-cycle expected strobes,
// a negedge monitor pops and compares; a small PC model checks program-counter effects.
module tb_controller;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    controller_if ifc ();

    controller dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    // {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}
    logic [8:0] outs;
    assign outs = {ifc.sel, ifc.rd, ifc.ld_ir, ifc.inc_pc, ifc.ld_pc,
                   ifc.halt, ifc.data_e, ifc.ld_ac, ifc.wr};

    typedef struct {
        string      name;
        logic [8:0] exp;
    } item_t;

    item_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    // Datapath-side program counter model; ld_pc has priority over inc_pc.
    logic [4:0] pc;
    logic [4:0] pc_set_val;
    logic [4:0] load_addr;
    logic       pc_set;

    always @(posedge clk) begin
        if (pc_set)          pc <= pc_set_val;
        else if (ifc.ld_pc)  pc <= load_addr;
        else if (ifc.inc_pc) pc <= pc + 5'd1;
    end

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_pc(input string name, input logic [4:0] exp);
        checks++;
        if (pc !== exp) begin
            failures++;
            $display("FAIL %s: pc got %b expected %b", name, pc, exp);
        end
    endtask

    always @(negedge clk) begin
        item_t it;
        checks++;
        if (ifc.wr && ifc.rd) begin
            failures++;
            $display("FAIL wr_rd_excl: wr=%b rd=%b expected not both 1", ifc.wr, ifc.rd);
        end
        if (sb.size() != 0) begin
            it = sb.pop_front();
            check(it.name, outs, it.exp);
        end
    end

    // One clock step: expectation for the cycle starting now, checked at the negedge.
    task automatic step(input string name, input logic [8:0] exp);
        item_t it;
        it.name = name;
        it.exp  = exp;
        sb.push_back(it);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    localparam logic [8:0] Ph0 = 9'b100000000;
    localparam logic [8:0] Ph1 = 9'b110000000;
    localparam logic [8:0] Ph2 = 9'b111000000;
    localparam logic [8:0] Ph3 = 9'b111000000;

    // tail packs expected vectors for phases 4..7, phase 4 in the top bits.
    task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                             input logic glitch, input logic [4:0] pc0,
                             input logic [35:0] tail);
        ifc.opcode = op;
        ifc.zero   = glitch ? ~z : z;
        pc_set     = 1'b1;
        pc_set_val = pc0;
        step($sformatf("%s_ph0", tag), Ph0);
        pc_set = 1'b0;
        step($sformatf("%s_ph1", tag), Ph1);
        step($sformatf("%s_ph2", tag), Ph2);
        step($sformatf("%s_ph3", tag), Ph3);
        for (int i = 0; i < 4; i++) begin
            ifc.zero = (glitch && i != 2) ? ~z : z;
            step($sformatf("%s_ph%0d", tag, i + 4), tail[35 - 9 * i -: 9]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        ifc.opcode = 3'd2;
        ifc.zero   = 1'b0;
        pc_set     = 1'b0;
        pc_set_val = 5'd0;
        load_addr  = 5'b10101;
        @(posedge clk);
        #1;
        step("reset0", Ph0);
        step("reset1", Ph0);
        rst = 1'b0;

        run_instr("add", 3'd2, 1'b0, 1'b0, 5'b00011,
                  {9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010});
        check_pc("add_pc", 5'b00100);

        run_instr("skz1", 3'd1, 1'b1, 1'b0, 5'b00000,
                  {9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000});
        check_pc("skz1_pc", 5'b00010);

        // zero toggles outside ALU_OP must not cause a skip.
        run_instr("skz0", 3'd1, 1'b0, 1'b1, 5'b00000,
                  {9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000});
        check_pc("skz0_pc", 5'b00001);

        run_instr("jmp", 3'd7, 1'b0, 1'b0, 5'b01001,
                  {9'b000100000, 9'b000000000, 9'b000010000, 9'b000010000});
        check_pc("jmp_pc", 5'b10101);

        run_instr("sto", 3'd6, 1'b0, 1'b0, 5'b00111,
                  {9'b000100000, 9'b000000000, 9'b000000100, 9'b000000101});
        check_pc("sto_pc", 5'b01000);

        ifc.opcode = 3'd0;
        ifc.zero   = 1'b0;
        pc_set     = 1'b1;
        pc_set_val = 5'b01010;
        step("hlt_ph0", Ph0);
        pc_set = 1'b0;
        step("hlt_ph1", Ph1);
        step("hlt_ph2", Ph2);
        step("hlt_ph3", Ph3);
        step("hlt_ph4", 9'b000001000);
        for (int i = 0; i < 20; i++) begin
            ifc.zero = i[0];
            step($sformatf("hlt_hold%0d", i), 9'b000001000);
        end
        check_pc("hlt_pc", 5'b01010);

        // Mid-clock reset while halted returns to INST_ADDR at once.
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid", outs, Ph0);
        step("rst_hold", Ph0);
        rst = 1'b0;

        run_instr("add2", 3'd2, 1'b0, 1'b0, 5'b00011,
                  {9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010});
        check_pc("add2_pc", 5'b00100);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
